// File: rtl/or16_pkg.sv
// or16_pkg: shared width, constants and word type for the registered OR stage.
package or16_pkg;
  localparam int OR16_WIDTH = 16;
  typedef logic [OR16_WIDTH-1:0] or16_word_t;
  localparam or16_word_t OR16_ZERO = '0;
  localparam or16_word_t OR16_ONES = '1;
endpackage

// File: rtl/or16_pipe_if.sv
// or16_pipe_if: operand/result handshake bundle for or16_pipe.
//   in_valid/in_ready/a/b  : operand side (producer -> unit)
//   out_valid/out_ready/out: result side (unit -> consumer)
//   out_zero/out_ones      : result flags, present only with OR16_FLAGS_EN
// master = bench/producer+consumer side, slave = the OR unit.
interface or16_pipe_if import or16_pkg::*; #(parameter int WIDTH = OR16_WIDTH);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
`ifdef OR16_FLAGS_EN
  logic             out_zero;
  logic             out_ones;
`endif

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out
`ifdef OR16_FLAGS_EN
    , input out_zero, out_ones
`endif
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out
`ifdef OR16_FLAGS_EN
    , output out_zero, out_ones
`endif
  );
endinterface

// File: rtl/or_nand_slice.sv
// or_nand_slice: 1-bit OR built from NAND gates, y = NAND(NAND(a,a), NAND(b,b)).
//   a, b : operand bits
//   y    : a | b
module or_nand_slice (
  input  logic a,
  input  logic b,
  output logic y
);
  logic na, nb;

  assign na = ~(a & a);
  assign nb = ~(b & b);
  assign y  = ~(na & nb);
endmodule

// File: rtl/or16_pipe.sv
// or16_pipe: registered WIDTH-bit bitwise OR with valid/ready on both sides.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : or16_pipe_if.slave (operands in, result out, optional flags)
// One-cycle latency, single-entry output register; drain and accept in the
// same cycle keep the register full for full throughput.
// Build option: define OR16_FLAGS_EN to add registered out_zero/out_ones.
module or16_pipe import or16_pkg::*; #(
  parameter int WIDTH = OR16_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  or16_pipe_if.slave bus
);
  logic [WIDTH-1:0] or_w;
  logic [WIDTH-1:0] res_q;
  logic             vld_q;
  logic             accept;

  // bitwise OR datapath, one NAND slice per bit
  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    or_nand_slice u_slice (.a(bus.a[i]), .b(bus.b[i]), .y(or_w[i]));
  end

  // ready only looks at the output register, never at in_valid
  assign bus.in_ready = !vld_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      res_q <= '0;
    end else if (accept) begin
      vld_q <= 1'b1;
      res_q <= or_w;
    end else if (bus.out_ready) begin
      vld_q <= 1'b0;  // drain; result value is kept
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.out       = res_q;

`ifdef OR16_FLAGS_EN
  logic zero_q, ones_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      ones_q <= 1'b0;
    end else if (accept) begin
      zero_q <= ~|or_w;
      ones_q <= &or_w;
    end
  end

  assign bus.out_zero = zero_q;
  assign bus.out_ones = ones_q;
`endif
endmodule

// File: tb/tb_or16_pipe.sv
// tb_or16_pipe: directed checks of or16_pipe plus a randomised scoreboard run.
module tb_or16_pipe;
  import or16_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  or16_pipe_if #(.WIDTH(16)) bus ();
  or16_pipe #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  // all driving and sampling happens 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.in_valid = 1'b1; bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0; bus.in_valid = 1'b0;
    #1;
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
    n_chk++; if (bus.out !== 16'h0000) begin n_fail++; $display("FAIL reset_out got %h want 0000", bus.out); end
    n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", bus.in_ready); end
`ifdef OR16_FLAGS_EN
    n_chk++; if (bus.out_zero !== 1'b0 || bus.out_ones !== 1'b0) begin n_fail++; $display("FAIL reset_flags got %b%b want 00", bus.out_zero, bus.out_ones); end
`endif
  endtask

  task automatic test_zero();
    bus.in_valid = 1'b1; bus.a = 16'h0000; bus.b = 16'h0000; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.a = 16'hFFFF; bus.b = 16'hFFFF;
    n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL zero_valid got %b want 1", bus.out_valid); end
    n_chk++; if (bus.out !== 16'h0000) begin n_fail++; $display("FAIL zero_out got %h want 0000", bus.out); end
`ifdef OR16_FLAGS_EN
    n_chk++; if (bus.out_zero !== 1'b1 || bus.out_ones !== 1'b0) begin n_fail++; $display("FAIL zero_flags got %b%b want 10", bus.out_zero, bus.out_ones); end
`endif
    tick();
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_drain got %b want 0", bus.out_valid); end
    n_chk++; if (bus.out !== 16'h0000) begin n_fail++; $display("FAIL zero_keep got %h want 0000", bus.out); end
  endtask

  task automatic test_back_to_back();
    bus.in_valid = 1'b1; bus.a = 16'hFFFF; bus.b = 16'h0000; bus.out_ready = 1'b1;
    tick();
    n_chk++; if (bus.out !== 16'hFFFF || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first got %h/%b want FFFF/1", bus.out, bus.out_valid); end
    n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b want 1", bus.in_ready); end
    bus.a = 16'h0000; bus.b = 16'hFFFF;
    tick();
    n_chk++; if (bus.out !== 16'hFFFF || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second got %h/%b want FFFF/1", bus.out, bus.out_valid); end
    bus.a = 16'hAAAA; bus.b = 16'h5555;
    tick();
    n_chk++; if (bus.out !== 16'hFFFF || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_alt got %h/%b want FFFF/1", bus.out, bus.out_valid); end
    bus.a = 16'h00F0; bus.b = 16'h0C03;
    tick();
    bus.in_valid = 1'b0;
    n_chk++; if (bus.out !== 16'h0CF3) begin n_fail++; $display("FAIL b2b_mixed got %h want 0CF3", bus.out); end
    tick();
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_ones();
    bus.in_valid = 1'b1; bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_chk++; if (bus.out !== 16'hFFFF) begin n_fail++; $display("FAIL ones_out got %h want FFFF", bus.out); end
`ifdef OR16_FLAGS_EN
    n_chk++; if (bus.out_zero !== 1'b0 || bus.out_ones !== 1'b1) begin n_fail++; $display("FAIL ones_flags got %b%b want 01", bus.out_zero, bus.out_ones); end
`endif
    tick();
  endtask

  task automatic test_stall();
    bus.in_valid = 1'b1; bus.a = 16'h1234; bus.b = 16'h0F00; bus.out_ready = 1'b0;
    tick();
    // offered operands during the stall must be ignored
    bus.a = 16'h8001; bus.b = 16'h4002;
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (bus.out !== 16'h1F34 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold[%0d] got %h/%b want 1F34/1", i, bus.out, bus.out_valid); end
      n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d] got %b want 0", i, bus.in_ready); end
      tick();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    #1;
    n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready got %b want 1", bus.in_ready); end
    tick();
    n_chk++; if (bus.out_valid !== 1'b0 || bus.out !== 16'h1F34) begin n_fail++; $display("FAIL stall_drain got %h/%b want 1F34/0", bus.out, bus.out_valid); end
  endtask

  task automatic test_reset_pending();
    bus.in_valid = 1'b1; bus.a = 16'hFFFF; bus.b = 16'h0000; bus.out_ready = 1'b0;
    tick();
    n_chk++; if (bus.out_valid !== 1'b1 || bus.out !== 16'hFFFF) begin n_fail++; $display("FAIL rstp_pending got %h/%b want FFFF/1", bus.out, bus.out_valid); end
    // reset wins over an accept offered in the same cycle
    rst = 1'b1; bus.out_ready = 1'b1; bus.a = 16'h0101;
    tick();
    rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #1;
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstp_valid got %b want 0", bus.out_valid); end
    n_chk++; if (bus.out !== 16'h0000) begin n_fail++; $display("FAIL rstp_out got %h want 0000", bus.out); end
    n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstp_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_random();
    logic [15:0] q[$];
    int acc = 0, done = 0, cyc = 0;
    logic exp_rdy;
    while ((acc < 1000 || q.size() != 0) && cyc < 20000) begin
      bus.in_valid  = (acc < 1000) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
      bus.a         = 16'($urandom);
      bus.b         = 16'($urandom);
      bus.out_ready = 1'($urandom_range(0, 2) != 0);
      #1;
      exp_rdy = (q.size() == 0) || bus.out_ready;
      n_chk++; if (bus.in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready cyc %0d got %b want %b", cyc, bus.in_ready, exp_rdy); end
      n_chk++; if (bus.out_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid cyc %0d got %b want %b", cyc, bus.out_valid, q.size() != 0); end
      if (bus.out_valid && bus.out_ready && q.size() != 0) begin
        n_chk++; if (bus.out !== q[0]) begin n_fail++; $display("FAIL rnd_data txn %0d got %h want %h", done, bus.out, q[0]); end
        void'(q.pop_front());
        done++;
      end
      if (bus.in_valid && exp_rdy) begin
        q.push_back(bus.a | bus.b);
        acc++;
      end
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    n_chk++; if (done != 1000) begin n_fail++; $display("FAIL rnd_count got %0d want 1000 (cycles %0d)", done, cyc); end
  endtask

  initial begin
    rst = 1'b0; bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
    test_reset();
    test_zero();
    test_back_to_back();
    test_ones();
    test_stall();
    test_reset_pending();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
